// File: rtl/intra_mode_decision_ctrl_pkg.sv
// Shared constants, FSM encoding and QP-to-lambda table for intra 4x4 mode decision.
package intra_mode_decision_ctrl_pkg;

   localparam int SATD_W   = 16;
   localparam int COST_W   = SATD_W + 1;
   localparam int BLK_NUM  = 16;
   localparam int LAMBDA_W = 7;

   localparam logic [3:0]        MODE_NUM     = 4'd9;
   localparam logic [3:0]        INVALID_MODE = 4'hF;
   localparam logic [3:0]        LAST_BLK     = 4'(BLK_NUM - 1);
   localparam logic [COST_W-1:0] COST_MAX     = {COST_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // QPs above 51 are outside the table and carry no rate penalty.
   function automatic logic [LAMBDA_W-1:0] lambda_of_qp(input logic [5:0] qp);
      logic [LAMBDA_W-1:0] lam;
      if (qp <= 6'd15) begin
         lam = 7'd1;
      end else if (qp <= 6'd19) begin
         lam = 7'd2;
      end else if (qp <= 6'd22) begin
         lam = 7'd3;
      end else if (qp <= 6'd25) begin
         lam = 7'd4;
      end else begin
         case (qp)
            6'd26:        lam = 7'd5;
            6'd27, 6'd28: lam = 7'd6;
            6'd29:        lam = 7'd7;
            6'd30:        lam = 7'd8;
            6'd31:        lam = 7'd9;
            6'd32:        lam = 7'd10;
            6'd33:        lam = 7'd11;
            6'd34:        lam = 7'd13;
            6'd35:        lam = 7'd14;
            6'd36:        lam = 7'd16;
            6'd37:        lam = 7'd18;
            6'd38:        lam = 7'd20;
            6'd39:        lam = 7'd23;
            6'd40:        lam = 7'd25;
            6'd41:        lam = 7'd29;
            6'd42:        lam = 7'd32;
            6'd43:        lam = 7'd36;
            6'd44:        lam = 7'd40;
            6'd45:        lam = 7'd45;
            6'd46:        lam = 7'd51;
            6'd47:        lam = 7'd57;
            6'd48:        lam = 7'd64;
            6'd49:        lam = 7'd72;
            6'd50:        lam = 7'd81;
            6'd51:        lam = 7'd91;
            default:      lam = 7'd0;
         endcase
      end
      return lam;
   endfunction

endpackage

// File: rtl/intra_mode_decision_ctrl_if.sv
// Cost-beat input and block-result output bundle of the intra mode decision controller.
interface intra_mode_decision_ctrl_if;
   import intra_mode_decision_ctrl_pkg::*;

   logic              start_i;
   logic [5:0]        qp_i;
   logic              ready_o;
   logic [3:0]        pred_mode_i;
   logic              cost_valid_i;
   logic [3:0]        cost_mode_i;
   logic [SATD_W-1:0] cost_satd_i;
   logic              cost_last_i;
   logic              best_valid_o;
   logic [3:0]        best_mode_o;
   logic [COST_W-1:0] best_cost_o;
   logic [3:0]        blk_idx_o;
   logic              mb_done_o;

   modport slave (
      input  start_i, qp_i, pred_mode_i, cost_valid_i, cost_mode_i, cost_satd_i, cost_last_i,
      output ready_o, best_valid_o, best_mode_o, best_cost_o, blk_idx_o, mb_done_o
   );

   modport master (
      output start_i, qp_i, pred_mode_i, cost_valid_i, cost_mode_i, cost_satd_i, cost_last_i,
      input  ready_o, best_valid_o, best_mode_o, best_cost_o, blk_idx_o, mb_done_o
   );

endinterface

// File: rtl/intra_mode_decision_ctrl_lambda.sv
// Registered QP-to-lambda lookup, loaded once per macroblock.
module intra_mode_decision_ctrl_lambda
   import intra_mode_decision_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_en,
   input  logic [5:0]          qp,
   output logic [LAMBDA_W-1:0] lambda_r
);

   // Capture lambda for the macroblock QP; hold it for all 16 blocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lambda_r <= {LAMBDA_W{1'b0}};
      end else if (load_en) begin
         lambda_r <= lambda_of_qp(qp);
      end else begin
         lambda_r <= lambda_r;
      end
   end

endmodule

// File: rtl/intra_mode_decision_ctrl.sv
// Intra 4x4 RD mode decision sequencer: penalises non-predicted modes by 4*lambda and keeps the cheapest mode per block.
module intra_mode_decision_ctrl
   import intra_mode_decision_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   intra_mode_decision_ctrl_if.slave   bus
);

   state_e              state_r;
   logic [5:0]          qp_r;
   logic [3:0]          pred_r;
   logic                first_r;
   logic [LAMBDA_W-1:0] lambda_r;
   logic                ready_r;
   logic                best_valid_r;
   logic                mb_done_r;
   logic [3:0]          best_mode_r;
   logic [COST_W-1:0]   best_cost_r;
   logic [3:0]          blk_idx_r;

   logic                load_s;
   logic                beat_s;
   logic                upd_s;
   logic                last_blk_s;
   logic [3:0]          eff_pred_s;
   logic [8:0]          penalty_s;
   logic [COST_W-1:0]   cost_s;

   intra_mode_decision_ctrl_lambda u_lambda (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (load_s),
      .qp       (qp_r),
      .lambda_r (lambda_r)
   );

   // Beat acceptance and penalised cost; the first beat of a block uses pred_mode_i directly.
   always_comb begin
      load_s     = (state_r == ST_LOAD);
      beat_s     = (state_r == ST_EVAL) && bus.cost_valid_i;
      last_blk_s = (blk_idx_r == LAST_BLK);
      if (first_r) begin
         eff_pred_s = bus.pred_mode_i;
      end else begin
         eff_pred_s = pred_r;
      end
      if (bus.cost_mode_i == eff_pred_s) begin
         penalty_s = 9'd0;
      end else begin
         penalty_s = {lambda_r, 2'b00};
      end
      cost_s = {1'b0, bus.cost_satd_i} + {{(COST_W-9){1'b0}}, penalty_s};
      upd_s  = beat_s && (bus.cost_mode_i < MODE_NUM) && (cost_s < best_cost_r);
   end

   // Control FSM with all block-result outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         qp_r         <= 6'd0;
         pred_r       <= 4'd0;
         first_r      <= 1'b0;
         ready_r      <= 1'b0;
         best_valid_r <= 1'b0;
         mb_done_r    <= 1'b0;
         best_mode_r  <= INVALID_MODE;
         best_cost_r  <= COST_MAX;
         blk_idx_r    <= 4'd0;
      end else begin
         best_valid_r <= 1'b0;
         mb_done_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start_i) begin
                  qp_r    <= bus.qp_i;
                  state_r <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               best_mode_r <= INVALID_MODE;
               best_cost_r <= COST_MAX;
               blk_idx_r   <= 4'd0;
               first_r     <= 1'b1;
               ready_r     <= 1'b1;
               state_r     <= ST_EVAL;
            end
            ST_EVAL: begin
               if (beat_s) begin
                  first_r <= 1'b0;
                  if (first_r) begin
                     pred_r <= bus.pred_mode_i;
                  end
                  // Strict compare: a tie keeps the earlier beat.
                  if (upd_s) begin
                     best_mode_r <= bus.cost_mode_i;
                     best_cost_r <= cost_s;
                  end
                  if (bus.cost_last_i) begin
                     ready_r      <= 1'b0;
                     best_valid_r <= 1'b1;
                     mb_done_r    <= last_blk_s;
                     state_r      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (last_blk_s) begin
                  blk_idx_r <= 4'd0;
                  state_r   <= ST_IDLE;
               end else begin
                  blk_idx_r   <= blk_idx_r + 4'd1;
                  best_mode_r <= INVALID_MODE;
                  best_cost_r <= COST_MAX;
                  first_r     <= 1'b1;
                  ready_r     <= 1'b1;
                  state_r     <= ST_EVAL;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o      = ready_r;
   assign bus.best_valid_o = best_valid_r;
   assign bus.best_mode_o  = best_mode_r;
   assign bus.best_cost_o  = best_cost_r;
   assign bus.blk_idx_o    = blk_idx_r;
   assign bus.mb_done_o    = mb_done_r;

endmodule

// File: tb/tb_intra_mode_decision_ctrl.sv
// Randomised scoreboard bench for intra_mode_decision_ctrl with a behavioural RD-cost model.
module tb_intra_mode_decision_ctrl;
   import intra_mode_decision_ctrl_pkg::*;

   typedef struct { int mode; int cost; int blk; int done; } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   intra_mode_decision_ctrl_if bus ();
   intra_mode_decision_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   int   bm[$];
   int   bs[$];
   int   bpred;

   // Lambda per QP 0..51; anything above has no penalty.
   int lam_tab [52] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1, 2,2,2,2, 3,3,3, 4,4,4, 5, 6,6,
                        7,8,9,10,11,13,14,16,18,20,23,25,29,32,36,40,45,51,57,64,72,81,91};

   function automatic int ref_lambda(input int qp);
      if (qp < 52) return lam_tab[qp];
      return 0;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic check_reset_state();
      check("rst_ready",      bus.ready_o,      0);
      check("rst_best_valid", bus.best_valid_o, 0);
      check("rst_best_mode",  bus.best_mode_o,  15);
      check("rst_best_cost",  bus.best_cost_o,  'h1FFFF);
      check("rst_blk_idx",    bus.blk_idx_o,    0);
      check("rst_mb_done",    bus.mb_done_o,    0);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.ready_o !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.ready_o !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL ready_timeout got=%0b expected=1", bus.ready_o);
      end
   endtask

   task automatic fill_block(input int kind, input int b);
      int n;
      bm.delete();
      bs.delete();
      if (kind == 1 && b == 0) begin
         bpred = 2;
         bm.push_back(0); bs.push_back(100);
         bm.push_back(1); bs.push_back(90);
         bm.push_back(2); bs.push_back(110);
      end else if (kind == 1 && b == 1) begin
         bpred = $urandom_range(0, 8);
         bm.push_back(9); bs.push_back($urandom_range(0, 65535));
      end else if (kind == 2 && b == 0) begin
         bpred = 0;
         bm.push_back(0); bs.push_back(50);
         bm.push_back(1); bs.push_back(46);
      end else if (kind == 3 && b == 0) begin
         bpred = 0;
         bm.push_back(1); bs.push_back(65535);
      end else begin
         bpred = $urandom_range(0, 8);
         n = (kind == 4) ? 9 : $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            if (kind == 4) bm.push_back(i);
            else if ($urandom_range(0, 9) == 0) bm.push_back($urandom_range(9, 15));
            else bm.push_back($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) bs.push_back($urandom_range(0, 60));
            else bs.push_back($urandom_range(0, 65535));
         end
      end
   endtask

   task automatic send_block(input int b, input int lam, input bit glitch);
      exp_t e;
      int   c;
      e.mode = 15;
      e.cost = 'h1FFFF;
      e.blk  = b;
      e.done = (b == BLK_NUM - 1) ? 1 : 0;
      // Cheapest legal mode wins; non-predicted modes pay 4*lambda; first of equal costs kept.
      for (int i = 0; i < bm.size(); i++) begin
         if (bm[i] <= 8) begin
            c = bs[i] + ((bm[i] == bpred) ? 0 : 4 * lam);
            if (c < e.cost) begin
               e.cost = c;
               e.mode = bm[i];
            end
         end
      end
      exp_q.push_back(e);
      wait_ready();
      for (int i = 0; i < bm.size(); i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.cost_valid_i = 1'b0;
            @(posedge clk); #1;
         end
         bus.cost_valid_i = 1'b1;
         bus.cost_mode_i  = 4'(bm[i]);
         bus.cost_satd_i  = 16'(bs[i]);
         bus.cost_last_i  = (i == bm.size() - 1);
         bus.pred_mode_i  = (i == 0) ? 4'(bpred) : 4'($urandom_range(0, 15));
         bus.qp_i         = 6'($urandom_range(0, 63));
         bus.start_i      = glitch;
         @(posedge clk); #1;
      end
      bus.cost_valid_i = 1'b0;
      bus.cost_last_i  = 1'b0;
      bus.start_i      = 1'b0;
      check("result_latency_valid_ready", {bus.best_valid_o, bus.ready_o}, 2'b10);
   endtask

   task automatic run_mb(input int qp, input int kind, input int stop_blk);
      int lam;
      lam = ref_lambda(qp);
      bus.start_i = 1'b1;
      bus.qp_i    = 6'(qp);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int b = 0; b < stop_blk; b++) begin
         fill_block(kind, b);
         send_block(b, lam, (kind == 1 && b == 1));
      end
      if (stop_blk < BLK_NUM) begin
         wait_ready();
         for (int i = 0; i < 2; i++) begin
            bus.cost_valid_i = 1'b1;
            bus.cost_mode_i  = 4'($urandom_range(0, 8));
            bus.cost_satd_i  = 16'($urandom_range(0, 200));
            bus.cost_last_i  = 1'b0;
            @(posedge clk); #1;
         end
         bus.cost_valid_i = 1'b0;
         rst_n = 1'b0;
         @(posedge clk); #1;
         check_reset_state();
         rst_n = 1'b1;
         return;
      end
      @(posedge clk); #1;
      check("mb_idle_ready",   bus.ready_o,   0);
      check("mb_idle_blk_idx", bus.blk_idx_o, 0);
   endtask

   // Monitor: pops one expected result per best_valid pulse.
   initial begin : monitor
      exp_t e;
      bit   prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.best_valid_o === 1'b1) begin
            if (prev_valid) begin
               vectors++;
               miscompares++;
               $display("FAIL pulse_width got=2+ cycles expected=1 cycle");
            end
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_result got mode=%0d cost=%0d idx=%0d expected=no result",
                        bus.best_mode_o, bus.best_cost_o, bus.blk_idx_o);
            end else begin
               e = exp_q.pop_front();
               vectors++;
               if (bus.best_mode_o !== 4'(e.mode) || bus.best_cost_o !== 17'(e.cost) ||
                   bus.blk_idx_o !== 4'(e.blk) || bus.mb_done_o !== 1'(e.done)) begin
                  miscompares++;
                  $display("FAIL block_result got mode=%0d cost=%0d idx=%0d done=%0b expected mode=%0d cost=%0d idx=%0d done=%0d",
                           bus.best_mode_o, bus.best_cost_o, bus.blk_idx_o, bus.mb_done_o,
                           e.mode, e.cost, e.blk, e.done);
               end
            end
         end else if (bus.mb_done_o === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL mb_done_alone got=1 expected=0");
         end
         prev_valid = (bus.best_valid_o === 1'b1);
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin : driver
      bus.start_i      = 1'b0;
      bus.qp_i         = 6'd0;
      bus.pred_mode_i  = 4'd0;
      bus.cost_valid_i = 1'b0;
      bus.cost_mode_i  = 4'd0;
      bus.cost_satd_i  = 16'd0;
      bus.cost_last_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_mb(28, 1, BLK_NUM);
      run_mb(0,  2, BLK_NUM);
      run_mb(51, 3, BLK_NUM);
      run_mb(55, 3, BLK_NUM);
      for (int q = 0; q < 64; q++) begin
         run_mb(q, (q == 30) ? 4 : 0, BLK_NUM);
      end

      run_mb(30, 0, 5);
      @(posedge clk); #1;
      run_mb($urandom_range(0, 63), 0, BLK_NUM);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
